// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: upstream controller for clk_mux_glitch_free.
// Accepts clock-switch requests over valid/ready in the reference domain. A request is
// refused when its target clock has stopped toggling. After each switch, async_sel_o is
// held for a settle window before the response is returned.
module clk_sel_ctrl #(
    parameter int NUM_INPUTS    = 2,
    parameter int SelWidth      = $clog2(NUM_INPUTS),
    parameter int REF_IDX       = 0,
    parameter int RESET_SEL     = 0,
    parameter int HB_DIV_LOG2   = 2,
    parameter int ALIVE_TIMEOUT = 64,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic [NUM_INPUTS-1:0] clks_i,
    input  logic [NUM_INPUTS-1:0] s_reset_synced,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [SelWidth-1:0]   req_sel_i,
    output logic                  rsp_valid_o,
    output logic                  rsp_err_o,
    output logic [SelWidth-1:0]   async_sel_o,
    output logic                  busy_o,
    output logic [NUM_INPUTS-1:0] clk_alive_o
);

    localparam int HB_W  = HB_DIV_LOG2 + 1;
    localparam int WD_W  = $clog2(ALIVE_TIMEOUT + 1);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [WD_W-1:0]     WD_LIMIT    = WD_W'(ALIVE_TIMEOUT);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SelWidth-1:0] RESET_SEL_W = SelWidth'(RESET_SEL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_SETTLE,
        S_RESP
    } state_e;

    logic clk_ref;
    logic rst_ref_n;

    assign clk_ref   = clks_i[REF_IDX];
    assign rst_ref_n = s_reset_synced[REF_IDX];

    // A target is usable only if it is a real input and its watchdog reports it running.
    // Out-of-range indices fall through the loop and are reported as not usable.
    function automatic logic tgt_usable(input logic [SelWidth-1:0]   t,
                                        input logic [NUM_INPUTS-1:0] alive);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (t == SelWidth'(i)) begin
                ok = alive[i];
            end
        end
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Per-domain heartbeat: the MSB of a small free-running counter toggles
    // at clks_i[i]/2^(HB_DIV_LOG2+1), slow enough to be sampled by the ref clock.
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] hb_msb;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_hb
        logic [HB_W-1:0] hb_cnt_q;
        logic [HB_W-1:0] hb_cnt_d;

        // Next heartbeat count: free-running increment
        always_comb begin
            hb_cnt_d = hb_cnt_q + 1'b1;
        end

        // Heartbeat counter in its own clock domain; frozen while that domain is in reset
        always_ff @(posedge clks_i[gi] or negedge s_reset_synced[gi]) begin
            if (!s_reset_synced[gi]) begin
                hb_cnt_q <= '0;
            end else begin
                hb_cnt_q <= hb_cnt_d;
            end
        end

        assign hb_msb[gi] = hb_cnt_q[HB_W-1];
    end

    // ------------------------------------------------------------------
    // Ref domain: two-flop synchronizer, edge detector and watchdogs
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] hb_s1_q, hb_s1_d;
    logic [NUM_INPUTS-1:0] hb_s2_q, hb_s2_d;
    logic [NUM_INPUTS-1:0] hb_s3_q, hb_s3_d;
    logic [WD_W-1:0]       wd_cnt_q [NUM_INPUTS];
    logic [WD_W-1:0]       wd_cnt_d [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] alive_q, alive_d;

    // Synchronizer shift and watchdog update; any heartbeat edge proves the clock runs
    always_comb begin
        hb_s1_d = hb_msb;
        hb_s2_d = hb_s1_q;
        hb_s3_d = hb_s2_q;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            wd_cnt_d[i] = wd_cnt_q[i];
            alive_d[i]  = alive_q[i];
            if (hb_s2_q[i] != hb_s3_q[i]) begin
                wd_cnt_d[i] = '0;
                alive_d[i]  = 1'b1;
            end else if (wd_cnt_q[i] != WD_LIMIT) begin
                wd_cnt_d[i] = wd_cnt_q[i] + 1'b1;
                if (wd_cnt_q[i] == WD_LIMIT - 1'b1) begin
                    alive_d[i] = 1'b0;
                end
            end
            // The ref clock is running by construction whenever this logic is clocked
            if (i == REF_IDX) begin
                alive_d[i] = 1'b1;
            end
        end
    end

    // Synchronizer, edge history and watchdog registers
    always_ff @(posedge clk_ref or negedge rst_ref_n) begin
        if (!rst_ref_n) begin
            hb_s1_q <= '0;
            hb_s2_q <= '0;
            hb_s3_q <= '0;
            alive_q <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wd_cnt_q[i] <= '0;
            end
        end else begin
            hb_s1_q <= hb_s1_d;
            hb_s2_q <= hb_s2_d;
            hb_s3_q <= hb_s3_d;
            alive_q <= alive_d;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wd_cnt_q[i] <= wd_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM: IDLE -> CHECK -> {RESP | SETTLE -> RESP} -> IDLE
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [SelWidth-1:0]  tgt_q, tgt_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SelWidth-1:0]  sel_q, sel_d;
    logic                 ready_q, ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 busy_q, busy_d;

    // Next state and registered-output values; defaults hold every register
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i && ready_q) begin
                    tgt_d   = req_sel_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Liveness is sampled here only; a clock dying later does not abort
                if (!tgt_usable(tgt_q, alive_q)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (tgt_q == sel_q) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    err_d   = 1'b0;
                    sel_d   = tgt_q;
                    cnt_d   = SETTLE_LAST;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered
        // (ready/busy) or the state being left (the response pulse).
        ready_d     = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_q == S_RESP);
        rsp_err_d   = (state_q == S_RESP) && err_q;
    end

    // FSM control and output registers; ref reset drops any pending response at once
    always_ff @(posedge clk_ref or negedge rst_ref_n) begin
        if (!rst_ref_n) begin
            state_q     <= S_IDLE;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            sel_q       <= RESET_SEL_W;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Latched target is pure data, only consumed in CHECK after being written
    always_ff @(posedge clk_ref) begin
        tgt_q <= tgt_d;
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign async_sel_o = sel_q;
    assign busy_o      = busy_q;
    assign clk_alive_o = alive_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed testbench for clk_sel_ctrl: a 2-input instance (ref 10, clk1 13) and a
// 3-input instance (adds a 17-unit clock) sharing the same reference clock.
module tb_clk_sel_ctrl;

    logic clk0 = 1'b0;
    logic clk1 = 1'b0;
    logic clk2 = 1'b0;
    logic clk1_en = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // 2-input DUT
    logic [1:0] rstn;
    logic       req_valid;
    logic       req_sel;
    logic       req_ready;
    logic       rsp_valid;
    logic       rsp_err;
    logic       async_sel;
    logic       busy;
    logic [1:0] alive;

    // 3-input DUT
    logic [2:0] rstn3;
    logic       req_valid3;
    logic [1:0] req_sel3;
    logic       req_ready3;
    logic       rsp_valid3;
    logic       rsp_err3;
    logic [1:0] async_sel3;
    logic       busy3;
    logic [2:0] alive3;

    always #5 clk0 = ~clk0;

    always begin
        #6;
        if (clk1_en) clk1 = ~clk1;
        #7;
        if (clk1_en) clk1 = ~clk1;
    end

    always begin
        #8;
        clk2 = ~clk2;
        #9;
        clk2 = ~clk2;
    end

    clk_sel_ctrl #(
        .NUM_INPUTS(2), .REF_IDX(0), .RESET_SEL(0), .HB_DIV_LOG2(2),
        .ALIVE_TIMEOUT(64), .SETTLE_CYCLES(16)
    ) dut (
        .clks_i({clk1, clk0}),
        .s_reset_synced(rstn),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_sel_i(req_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_err_o(rsp_err),
        .async_sel_o(async_sel),
        .busy_o(busy),
        .clk_alive_o(alive)
    );

    clk_sel_ctrl #(
        .NUM_INPUTS(3), .REF_IDX(0), .RESET_SEL(0), .HB_DIV_LOG2(2),
        .ALIVE_TIMEOUT(64), .SETTLE_CYCLES(16)
    ) dut3 (
        .clks_i({clk2, clk1, clk0}),
        .s_reset_synced(rstn3),
        .req_valid_i(req_valid3),
        .req_ready_o(req_ready3),
        .req_sel_i(req_sel3),
        .rsp_valid_o(rsp_valid3),
        .rsp_err_o(rsp_err3),
        .async_sel_o(async_sel3),
        .busy_o(busy3),
        .clk_alive_o(alive3)
    );

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic test_reset();
        #23;
        n_checks++; if (async_sel !== 1'b0) begin n_fail++; $display("FAIL rst_async_sel: got %0h expected 0", async_sel); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %0h expected 0", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %0h expected 0", rsp_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h expected 0", busy); end
        n_checks++; if (alive !== 2'b00) begin n_fail++; $display("FAIL rst_alive: got %0h expected 0", alive); end
        n_checks++; if (async_sel3 !== 2'd0) begin n_fail++; $display("FAIL rst_async_sel3: got %0h expected 0", async_sel3); end
        #4;
        rstn  = 2'b11;
        rstn3 = 3'b111;
        repeat (100) tick();
        n_checks++; if (alive !== 2'b11) begin n_fail++; $display("FAIL up_alive: got %0h expected 3", alive); end
        n_checks++; if (async_sel !== 1'b0) begin n_fail++; $display("FAIL up_async_sel: got %0h expected 0", async_sel); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL up_ready: got %0h expected 1", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL up_busy: got %0h expected 0", busy); end
        n_checks++; if (alive3 !== 3'b111) begin n_fail++; $display("FAIL up_alive3: got %0h expected 7", alive3); end
        n_checks++; if (req_ready3 !== 1'b1) begin n_fail++; $display("FAIL up_ready3: got %0h expected 1", req_ready3); end
    endtask

    task automatic test_switch();
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sw_ready_k0: got %0h expected 0", req_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy_k0: got %0h expected 1", busy); end
        n_checks++; if (async_sel !== 1'b0) begin n_fail++; $display("FAIL sw_sel_k0: got %0h expected 0", async_sel); end
        tick();
        n_checks++; if (async_sel !== 1'b1) begin n_fail++; $display("FAIL sw_sel_k1: got %0h expected 1", async_sel); end
        for (int n = 2; n <= 18; n++) begin
            tick();
            n_checks++;
            if (rsp_valid !== (n == 18)) begin
                n_fail++; $display("FAIL sw_rsp_valid at +%0d: got %0h expected %0h", n, rsp_valid, (n == 18));
            end
            if (n < 18) begin
                n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sw_ready at +%0d: got %0h expected 0", n, req_ready); end
            end
        end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL sw_rsp_err: got %0h expected 0", rsp_err); end
        n_checks++; if (async_sel !== 1'b1) begin n_fail++; $display("FAIL sw_sel_end: got %0h expected 1", async_sel); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_rsp_pulse: got %0h expected 0", rsp_valid); end
        // switch back to input 0
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (18) tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL back_rsp_valid: got %0h expected 1", rsp_valid); end
        n_checks++; if (async_sel !== 1'b0) begin n_fail++; $display("FAIL back_sel: got %0h expected 0", async_sel); end
    endtask

    task automatic test_dead_clock();
        clk1_en = 1'b0;
        repeat (80) tick();
        n_checks++; if (alive !== 2'b01) begin n_fail++; $display("FAIL dead_alive: got %0h expected 1", alive); end
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL dead_rsp_k1: got %0h expected 0", rsp_valid); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL dead_rsp_k2: got %0h expected 1", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL dead_err: got %0h expected 1", rsp_err); end
        n_checks++; if (async_sel !== 1'b0) begin n_fail++; $display("FAIL dead_sel: got %0h expected 0", async_sel); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL dead_rsp_k3: got %0h expected 0", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL dead_err_k3: got %0h expected 0", rsp_err); end
        clk1_en = 1'b1;
        repeat (30) tick();
        n_checks++; if (alive !== 2'b11) begin n_fail++; $display("FAIL revive_alive: got %0h expected 3", alive); end
    endtask

    task automatic test_three_inputs();
        // out-of-range target
        req_valid3 = 1'b1;
        req_sel3   = 2'd3;
        tick();
        req_valid3 = 1'b0;
        tick();
        n_checks++; if (rsp_valid3 !== 1'b0) begin n_fail++; $display("FAIL oor_rsp_k1: got %0h expected 0", rsp_valid3); end
        tick();
        n_checks++; if (rsp_valid3 !== 1'b1) begin n_fail++; $display("FAIL oor_rsp_k2: got %0h expected 1", rsp_valid3); end
        n_checks++; if (rsp_err3 !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %0h expected 1", rsp_err3); end
        n_checks++; if (async_sel3 !== 2'd0) begin n_fail++; $display("FAIL oor_sel: got %0h expected 0", async_sel3); end
        tick();
        // no-op: target equals current
        req_valid3 = 1'b1;
        req_sel3   = 2'd0;
        tick();
        req_valid3 = 1'b0;
        tick();
        n_checks++; if (rsp_valid3 !== 1'b0) begin n_fail++; $display("FAIL noop_rsp_k1: got %0h expected 0", rsp_valid3); end
        tick();
        n_checks++; if (rsp_valid3 !== 1'b1) begin n_fail++; $display("FAIL noop_rsp_k2: got %0h expected 1", rsp_valid3); end
        n_checks++; if (rsp_err3 !== 1'b0) begin n_fail++; $display("FAIL noop_err: got %0h expected 0", rsp_err3); end
        n_checks++; if (async_sel3 !== 2'd0) begin n_fail++; $display("FAIL noop_sel: got %0h expected 0", async_sel3); end
        tick();
        // real switch to the third input
        req_valid3 = 1'b1;
        req_sel3   = 2'd2;
        tick();
        req_valid3 = 1'b0;
        tick();
        n_checks++; if (async_sel3 !== 2'd2) begin n_fail++; $display("FAIL sw3_sel: got %0h expected 2", async_sel3); end
        repeat (17) tick();
        n_checks++; if (rsp_valid3 !== 1'b1) begin n_fail++; $display("FAIL sw3_rsp: got %0h expected 1", rsp_valid3); end
        n_checks++; if (rsp_err3 !== 1'b0) begin n_fail++; $display("FAIL sw3_err: got %0h expected 0", rsp_err3); end
    endtask

    task automatic test_ref_reset_in_settle();
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++; if (async_sel !== 1'b1) begin n_fail++; $display("FAIL rr_sel_pre: got %0h expected 1", async_sel); end
        repeat (3) tick();
        rstn[0] = 1'b0;
        #1;
        n_checks++; if (async_sel !== 1'b0) begin n_fail++; $display("FAIL rr_sel_reset: got %0h expected 0", async_sel); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy_reset: got %0h expected 0", busy); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_rsp_reset: got %0h expected 0", rsp_valid); end
        repeat (3) tick();
        rstn[0] = 1'b1;
        for (int n = 0; n < 25; n++) begin
            tick();
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_no_rsp at %0d: got %0h expected 0", n, rsp_valid); end
        end
        n_checks++; if (alive !== 2'b11) begin n_fail++; $display("FAIL rr_alive: got %0h expected 3", alive); end
        n_checks++; if (async_sel !== 1'b0) begin n_fail++; $display("FAIL rr_sel_post: got %0h expected 0", async_sel); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rr_ready_post: got %0h expected 1", req_ready); end
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++; if (async_sel !== 1'b1) begin n_fail++; $display("FAIL rr_new_sel: got %0h expected 1", async_sel); end
        repeat (17) tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_new_rsp: got %0h expected 1", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rr_new_err: got %0h expected 0", rsp_err); end
    endtask

    task automatic test_back_to_back();
        tick();
        // current select is 1; request 0 and keep valid high with a changing select
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick();
        req_sel = 1'b1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_k0: got %0h expected 0", req_ready); end
        for (int n = 1; n <= 18; n++) begin
            tick();
            req_sel = n[0];
            n_checks++; if (async_sel !== 1'b0) begin n_fail++; $display("FAIL b2b_sel at +%0d: got %0h expected 0", n, async_sel); end
            n_checks++;
            if (rsp_valid !== (n == 18)) begin
                n_fail++; $display("FAIL b2b_rsp at +%0d: got %0h expected %0h", n, rsp_valid, (n == 18));
            end
        end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %0h expected 0", rsp_err); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle: got %0h expected 1", req_ready); end
        req_sel = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b2_ready: got %0h expected 0", req_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b2_busy: got %0h expected 1", busy); end
        tick();
        n_checks++; if (async_sel !== 1'b1) begin n_fail++; $display("FAIL b2b2_sel: got %0h expected 1", async_sel); end
        repeat (17) tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b2_rsp: got %0h expected 1", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL b2b2_err: got %0h expected 0", rsp_err); end
    endtask

    initial begin
        rstn       = 2'b00;
        rstn3      = 3'b000;
        req_valid  = 1'b0;
        req_sel    = 1'b0;
        req_valid3 = 1'b0;
        req_sel3   = 2'd0;
        test_reset();
        test_switch();
        test_dead_clock();
        test_three_inputs();
        test_ref_reset_in_settle();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
